// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants and types for the traffic controller and phase timer
package traffic_pkg;

  localparam int TIMER_W = 5;

  localparam logic [TIMER_W-1:0] GREEN_TIME    = 5'd30;
  localparam logic [TIMER_W-1:0] ORANGE_TIME   = 5'd3;
  localparam logic [TIMER_W-1:0] TIMER_RST_VAL = GREEN_TIME;
  // Shown while a load is pending; never equals 1, so the controller holds its state.
  localparam logic [TIMER_W-1:0] LOADING_VAL   = 5'd0;

  // Light encoding shared with the controller (one-hot red/orange/green).
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_ORANGE = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Timer load sequencing: counting, or waiting to capture load_value.
  typedef enum logic {
    TMR_RUN     = 1'b0,
    TMR_CAPTURE = 1'b1
  } timer_state_e;

  // A phase time of 0 or 1 is treated as 1 so the count never underflows.
  function automatic logic [TIMER_W-1:0] floor_one(input logic [TIMER_W-1:0] v);
    return (v <= 5'd1) ? 5'd1 : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the system clock down to a one-cycle wrap pulse every TICK_DIV cycles
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic wrap
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over hold; wrap fires only on a counting terminal cycle.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase-duration countdown timer; optional freeze input via PHASE_TIMER_FREEZE_EN
module phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_counter,
  input  logic [TIMER_W-1:0] load_value,
`ifdef PHASE_TIMER_FREEZE_EN
  input  logic               freeze,
`endif
  output logic [TIMER_W-1:0] counter_value,
  output logic               tick,
  output logic               busy
);

  timer_state_e       state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               hold;
  logic               clr;
  logic               wrap;

`ifdef PHASE_TIMER_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  // Loads and the capture cycle both restart the one-second interval.
  assign clr = load_counter || (state_q == TMR_CAPTURE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .hold (hold),
    .wrap (wrap)
  );

  // Next state: load beats capture beats decrement; freeze suppresses wrap in the prescaler.
  always_comb begin
    state_d = TMR_RUN;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (load_counter) begin
      state_d = TMR_CAPTURE;
      cnt_d   = LOADING_VAL;
    end else if (state_q == TMR_CAPTURE) begin
      cnt_d   = floor_one(load_value);
    end else if (wrap) begin
      tick_d  = 1'b1;
      cnt_d   = (cnt_q > 5'd1) ? (cnt_q - 5'd1) : 5'd1;
    end
  end

  // State, counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TMR_RUN;
      cnt_q   <= TIMER_RST_VAL;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign counter_value = cnt_q;
  assign tick          = tick_q;
  assign busy          = (state_q == TMR_CAPTURE);

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - randomized and directed self-checking bench for phase_timer (TICK_DIV = 4)
module tb_phase_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_counter = 1'b0;
  logic [4:0] load_value = 5'd0;
`ifdef PHASE_TIMER_FREEZE_EN
  logic       freeze = 1'b0;
`endif
  logic [4:0] counter_value;
  logic       tick;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference state: displayed value, pending flag, last tick, cycles since interval restart.
  int m_val, m_busy, m_tick, m_age;

  always #5 clk = ~clk;

  phase_timer #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_counter (load_counter),
    .load_value   (load_value),
`ifdef PHASE_TIMER_FREEZE_EN
    .freeze       (freeze),
`endif
    .counter_value(counter_value),
    .tick         (tick),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val  = 30;
    m_busy = 0;
    m_tick = 0;
    m_age  = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit frz);
    if (ld) begin
      m_val = 0; m_busy = 1; m_tick = 0; m_age = 0;
    end else if (m_busy != 0) begin
      m_val = (lv < 2) ? 1 : lv; m_busy = 0; m_tick = 0; m_age = 0;
    end else if (frz) begin
      m_tick = 0;
    end else begin
      m_age++;
      if (m_age % TD == 0) begin
        m_tick = 1;
        m_val  = (m_val > 1) ? m_val - 1 : 1;
      end else begin
        m_tick = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_val"},  counter_value, m_val);
    chk({tag, "_busy"}, busy,          m_busy);
    chk({tag, "_tick"}, tick,          m_tick);
  endtask

  task automatic step(input bit ld, input int lv, input bit frz, input string tag);
    load_counter = ld;
    load_value   = lv[4:0];
`ifdef PHASE_TIMER_FREEZE_EN
    freeze       = frz;
`endif
    @(posedge clk);
    model_step(ld, lv, frz);
    #1;
    check_all(tag);
  endtask

  initial begin
    int nt;
    bit ld;
    int lv;

    // Reset and release
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_val", counter_value, 30);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_val",  counter_value, 30);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);

    // Full countdown from reset: 29 after 4 cycles, 1 after 116
    for (int i = 1; i <= 116; i++) begin
      step(1'b0, 0, 1'b0, "countdown");
      if (i == 4) chk("first_dec", counter_value, 29);
    end
    chk("reach_one", counter_value, 1);
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 0, 1'b0, "sat_hold");
      nt += int'(tick);
    end
    chk("sat_val", counter_value, 1);
    chk("sat_ticks", nt, 5);

    // Deferred load: 30 in N, 3 captured in N+1
    step(1'b1, 30, 1'b0, "dload_n1");
    chk("dload_sentinel", counter_value, 0);
    chk("dload_busy", busy, 1);
    step(1'b0, 3, 1'b0, "dload_n2");
    chk("dload_n2_val", counter_value, 3);
    repeat (4) step(1'b0, 3, 1'b0, "dload_run");
    chk("dload_n6_val", counter_value, 2);
    repeat (4) step(1'b0, 3, 1'b0, "dload_run");
    chk("dload_n10_val", counter_value, 1);
    repeat (8) step(1'b0, 3, 1'b0, "dload_hold");
    chk("dload_stay_one", counter_value, 1);

    // Zero load saturates to 1
    step(1'b1, 5, 1'b0, "zload_n1");
    step(1'b0, 0, 1'b0, "zload_n2");
    chk("zload_val", counter_value, 1);
    repeat (8) step(1'b0, 0, 1'b0, "zload_hold");
    chk("zload_no_wrap", counter_value, 1);

    // Load coinciding with the prescaler terminal cycle
    step(1'b1, 0, 1'b0, "coll_pre");
    step(1'b0, 20, 1'b0, "coll_pre");
    for (int g = 0; g < 2 * TD && (m_age % TD) != TD - 1; g++) step(1'b0, 20, 1'b0, "coll_align");
    chk("coll_aligned", m_age % TD, TD - 1);
    step(1'b1, 20, 1'b0, "coll_n1");
    chk("coll_no_tick", tick, 0);
    chk("coll_sentinel", counter_value, 0);
    step(1'b0, 20, 1'b0, "coll_n2");
    repeat (3) step(1'b0, 20, 1'b0, "coll_run");
    chk("coll_n5_val", counter_value, 20);
    step(1'b0, 20, 1'b0, "coll_n6");
    chk("coll_n6_val", counter_value, 19);
    chk("coll_n6_tick", tick, 1);

    // Back-to-back loads restart the capture
    step(1'b1, 9, 1'b0, "b2b_n1");
    step(1'b1, 9, 1'b0, "b2b_n2");
    chk("b2b_n2_val", counter_value, 0);
    chk("b2b_n2_busy", busy, 1);
    step(1'b0, 9, 1'b0, "b2b_n3");
    chk("b2b_n3_val", counter_value, 9);
    chk("b2b_n3_busy", busy, 0);

    // Randomized loads and values
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      lv = int'($urandom_range(0, 31));
      step(ld, lv, 1'b0, "rand");
    end

    // Asynchronous reset mid-countdown
    step(1'b1, 25, 1'b0, "arst_pre");
    step(1'b0, 25, 1'b0, "arst_pre");
    repeat (6) step(1'b0, 25, 1'b0, "arst_pre");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_val",  counter_value, 30);
    chk("arst_busy", busy, 0);
    chk("arst_tick", tick, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 0, 1'b0, "arst_post");

    // Asynchronous reset mid-load drops the pending capture
    step(1'b1, 7, 1'b0, "lrst_n1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("lrst_val",  counter_value, 30);
    chk("lrst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 7, 1'b0, "lrst_post");
    chk("lrst_dropped", counter_value, 30);
    repeat (4) step(1'b0, 7, 1'b0, "lrst_post");

`ifdef PHASE_TIMER_FREEZE_EN
    // Freeze holds the count; loads still land during freeze
    step(1'b1, 0, 1'b0, "frz_pre");
    step(1'b0, 17, 1'b0, "frz_pre");
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 17, 1'b1, "frz_hold");
      nt += int'(tick);
    end
    chk("frz_val", counter_value, 17);
    chk("frz_ticks", nt, 0);
    step(1'b1, 0, 1'b1, "frz_load_n1");
    step(1'b0, 12, 1'b1, "frz_load_n2");
    chk("frz_load_val", counter_value, 12);
    repeat (6) step(1'b0, 12, 1'b1, "frz_load_hold");
    chk("frz_load_held", counter_value, 12);
    repeat (TD) step(1'b0, 12, 1'b0, "frz_release");
    chk("frz_release_val", counter_value, 11);
    for (int i = 0; i < 200; i++) begin
      ld = ($urandom_range(0, 11) == 0);
      lv = int'($urandom_range(0, 31));
      step(ld, lv, ($urandom_range(0, 3) == 0), "frz_rand");
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
